// File: rtl/lcd_pkg.sv
// lcd_pkg - shared constants and types for the stopwatch LCD controller.
//   Command bytes, the arbiter FSM state enum, the requester id enum, the
//   byte-writer phase enum, and helpers that select init/line bytes.
// Build option: define LCD_INIT_REPEAT_EN to prefix the init sequence with
//   the three-byte 0x30 wake sequence.
package lcd_pkg;

  localparam logic [7:0] FUNC_SET = 8'h38;
  localparam logic [7:0] DISP_ON  = 8'h0C;
  localparam logic [7:0] ENTRY    = 8'h06;
  localparam logic [7:0] CLEAR    = 8'h01;
  localparam logic [7:0] LINE1    = 8'h80;
  localparam logic [7:0] LINE2    = 8'hC0;
  localparam logic [7:0] WAKE     = 8'h30;

  localparam logic [4:0] LINE_LEN = 5'd16;

`ifdef LCD_INIT_REPEAT_EN
  localparam logic [4:0] INIT_LEN = 5'd7;
  localparam logic       WAKE_EN  = 1'b1;
`else
  localparam logic [4:0] INIT_LEN = 5'd4;
  localparam logic       WAKE_EN  = 1'b0;
`endif

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    INIT  = 3'd1,
    IDLE  = 3'd2,
    ADDR  = 3'd3,
    DATA  = 3'd4,
    ACK   = 3'd5
  } lcd_state_e;

  typedef enum logic {
    LIVE = 1'b0,
    LAP  = 1'b1
  } req_id_e;

  typedef enum logic [2:0] {
    WR_IDLE  = 3'd0,
    WR_SETUP = 3'd1,
    WR_EHI   = 3'd2,
    WR_HOLD  = 3'd3,
    WR_WAIT  = 3'd4
  } wr_phase_e;

  // Byte number idx of the power-up command sequence.
  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    logic [7:0] b;
`ifdef LCD_INIT_REPEAT_EN
    case (idx)
      3'd0, 3'd1, 3'd2: b = WAKE;
      3'd3:             b = FUNC_SET;
      3'd4:             b = DISP_ON;
      3'd5:             b = ENTRY;
      3'd6:             b = CLEAR;
      default:          b = 8'h00;
    endcase
`else
    case (idx)
      3'd0:    b = FUNC_SET;
      3'd1:    b = DISP_ON;
      3'd2:    b = ENTRY;
      3'd3:    b = CLEAR;
      default: b = 8'h00;
    endcase
`endif
    return b;
  endfunction

  // Character idx of a 16-char line; char0 sits in bits [127:120].
  function automatic logic [7:0] line_char(input logic [127:0] line, input logic [3:0] idx);
    logic [127:0] sh;
    sh = line << {idx, 3'b000};
    return sh[127:120];
  endfunction

endpackage

// File: rtl/lcd_line_arbiter_writer.sv
// lcd_byte_writer - drives one byte onto the HD44780 bus with E-strobe timing.
//   SETUP (1 cycle, e=0) -> EHI (E_HIGH_CYC cycles, e=1) -> HOLD (1 cycle, e=0)
//   -> WAIT (CMD_WAIT_CYC, or CLR_WAIT_CYC for a clear) -> done pulse.
//   A new start is accepted in the same cycle that done is high, so the
//   byte-to-byte period is 3 + E_HIGH_CYC + wait cycles.
// Ports:
//   ckht, rst          clock, async active-high reset
//   start              launch a byte write (accepted when idle)
//   wr_byte, rs_in     byte and register select, latched on start
//   is_clear           selects the long post-clear wait, latched on start
//   done               one-cycle pulse after the wait completes
//   lcd_db/lcd_rs/lcd_e registered LCD bus outputs
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int E_HIGH_CYC   = 25,
  parameter int CMD_WAIT_CYC = 2_000,
  parameter int CLR_WAIT_CYC = 82_000
) (
  input  logic       ckht,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] wr_byte,
  input  logic       rs_in,
  input  logic       is_clear,
  output logic       done,
  output logic [7:0] lcd_db,
  output logic       lcd_rs,
  output logic       lcd_e
);

  localparam logic [31:0] E_LAST   = 32'(E_HIGH_CYC - 1);
  localparam logic [31:0] CMD_LAST = 32'(CMD_WAIT_CYC - 1);
  localparam logic [31:0] CLR_LAST = 32'(CLR_WAIT_CYC - 1);

  wr_phase_e   phase_r, phase_nx_s;
  logic [31:0] cnt_r, cnt_nx_s;
  logic [31:0] wait_last_s;
  logic        clr_r;
  logic [7:0]  db_r;
  logic        rs_r;
  logic        e_r, e_nx_s;
  logic        done_r, done_nx_s;

  assign wait_last_s = clr_r ? CLR_LAST : CMD_LAST;

  // Phase sequencing and next-cycle strobe/done values.
  always_comb begin
    phase_nx_s = phase_r;
    cnt_nx_s   = cnt_r;
    e_nx_s     = 1'b0;
    done_nx_s  = 1'b0;
    case (phase_r)
      WR_IDLE: begin
        if (start) begin
          phase_nx_s = WR_SETUP;
          cnt_nx_s   = 32'd0;
        end else begin
          phase_nx_s = WR_IDLE;
        end
      end
      WR_SETUP: begin
        phase_nx_s = WR_EHI;
        cnt_nx_s   = 32'd0;
        e_nx_s     = 1'b1;
      end
      WR_EHI: begin
        if (cnt_r == E_LAST) begin
          phase_nx_s = WR_HOLD;
          cnt_nx_s   = 32'd0;
        end else begin
          cnt_nx_s = cnt_r + 32'd1;
          e_nx_s   = 1'b1;
        end
      end
      WR_HOLD: begin
        phase_nx_s = WR_WAIT;
        cnt_nx_s   = 32'd0;
      end
      WR_WAIT: begin
        if (cnt_r == wait_last_s) begin
          phase_nx_s = WR_IDLE;
          cnt_nx_s   = 32'd0;
          done_nx_s  = 1'b1;
        end else begin
          cnt_nx_s = cnt_r + 32'd1;
        end
      end
      default: begin
        phase_nx_s = WR_IDLE;
        cnt_nx_s   = 32'd0;
      end
    endcase
  end

  // Phase register, bus latches and registered strobe outputs.
  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      phase_r <= WR_IDLE;
      cnt_r   <= 32'd0;
      clr_r   <= 1'b0;
      db_r    <= 8'h00;
      rs_r    <= 1'b0;
      e_r     <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      phase_r <= phase_nx_s;
      cnt_r   <= cnt_nx_s;
      e_r     <= e_nx_s;
      done_r  <= done_nx_s;
      if ((phase_r == WR_IDLE) && start) begin
        db_r  <= wr_byte;
        rs_r  <= rs_in;
        clr_r <= is_clear;
      end
    end
  end

  assign done   = done_r;
  assign lcd_db = db_r;
  assign lcd_rs = rs_r;
  assign lcd_e  = e_r;

endmodule

// File: rtl/lcd_line_arbiter.sv
// lcd_line_arbiter - HD44780 16x2 controller shared by two line requesters.
//   Runs power-up delay and init commands, then grants whole-line writes
//   round-robin between the live-time refresher (line 1) and the lap writer
//   (line 2). Each grant writes the line address then 16 data bytes.
// Build option: LCD_INIT_REPEAT_EN adds the 0x30 wake sequence before init;
//   the first wake byte is followed by a WAKE_WAIT_CYC wait.
// Ports:
//   ckht, rst            clock, async active-high reset
//   req_live, data_live  line-1 level request and text (char0 = [127:120])
//   req_lap,  data_lap   line-2 level request and text
//   ack_live, ack_lap    one-cycle completion pulses
//   busy                 high during init or any line transfer
//   init_done            high once init completes, until reset
//   lcd_db/lcd_rs/lcd_e  LCD bus, lcd_p LCD power enable
module lcd_line_arbiter
  import lcd_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int PWRUP_CYC     = 750_000,
  parameter int E_HIGH_CYC    = 25,
  parameter int CMD_WAIT_CYC  = 2_000,
  parameter int CLR_WAIT_CYC  = 82_000,
  parameter int WAKE_WAIT_CYC = (CLK_HZ / 10_000) * 41
) (
  input  logic         ckht,
  input  logic         rst,
  input  logic         req_live,
  input  logic [127:0] data_live,
  input  logic         req_lap,
  input  logic [127:0] data_lap,
  output logic         ack_live,
  output logic         ack_lap,
  output logic         busy,
  output logic         init_done,
  output logic [7:0]   lcd_db,
  output logic         lcd_rs,
  output logic         lcd_e,
  output logic         lcd_p
);

  localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_CYC - 1);
  // Extra cycles added after the first wake byte on top of its normal wait.
  localparam logic [31:0] WAKE_EXTRA = 32'(WAKE_WAIT_CYC - CMD_WAIT_CYC);

  lcd_state_e   state_r, state_nx_s;
  logic [31:0]  cnt_r, cnt_nx_s;
  logic [4:0]   idx_r, idx_nx_s;
  logic [127:0] line_r, line_nx_s;
  req_id_e      last_grant_r, last_nx_s, grant_s;
  logic         init_done_r, init_done_nx_s;
  logic         busy_r;
  logic         ack_live_r, ack_lap_r;
  logic         lcd_p_r;

  logic         wr_start_s;
  logic [7:0]   wr_byte_s;
  logic         wr_rs_s;
  logic         wr_clr_s;
  logic         wr_done_s;

  assign wr_clr_s = (wr_rs_s == 1'b0) && (wr_byte_s == CLEAR);

  // Next-state, arbitration and byte-writer launch decisions.
  always_comb begin
    state_nx_s     = state_r;
    cnt_nx_s       = cnt_r;
    idx_nx_s       = idx_r;
    line_nx_s      = line_r;
    last_nx_s      = last_grant_r;
    init_done_nx_s = init_done_r;
    grant_s        = last_grant_r;
    wr_start_s     = 1'b0;
    wr_byte_s      = 8'h00;
    wr_rs_s        = 1'b0;
    case (state_r)
      PWRUP: begin
        if (cnt_r == PWRUP_LAST) begin
          state_nx_s = INIT;
          cnt_nx_s   = 32'd0;
          idx_nx_s   = 5'd1;
          wr_start_s = 1'b1;
          wr_byte_s  = init_byte(3'd0);
        end else begin
          cnt_nx_s = cnt_r + 32'd1;
        end
      end
      INIT: begin
        // A non-zero count here is the extended wait after the first wake byte.
        if (cnt_r != 32'd0) begin
          cnt_nx_s = cnt_r - 32'd1;
          if (cnt_r == 32'd1) begin
            wr_start_s = 1'b1;
            wr_byte_s  = init_byte(idx_r[2:0]);
            idx_nx_s   = idx_r + 5'd1;
          end else begin
            wr_start_s = 1'b0;
          end
        end else if (wr_done_s) begin
          if (idx_r == INIT_LEN) begin
            state_nx_s     = IDLE;
            init_done_nx_s = 1'b1;
          end else if (WAKE_EN && (idx_r == 5'd1) && (WAKE_EXTRA != 32'd0)) begin
            cnt_nx_s = WAKE_EXTRA;
          end else begin
            wr_start_s = 1'b1;
            wr_byte_s  = init_byte(idx_r[2:0]);
            idx_nx_s   = idx_r + 5'd1;
          end
        end else begin
          state_nx_s = INIT;
        end
      end
      IDLE: begin
        // Round-robin only matters on a tie: favour whoever was not served last.
        if (req_live && req_lap) begin
          grant_s = (last_grant_r == LAP) ? LIVE : LAP;
        end else if (req_live) begin
          grant_s = LIVE;
        end else begin
          grant_s = LAP;
        end
        if (req_live || req_lap) begin
          state_nx_s = ADDR;
          last_nx_s  = grant_s;
          line_nx_s  = (grant_s == LIVE) ? data_live : data_lap;
          wr_start_s = 1'b1;
          wr_byte_s  = (grant_s == LIVE) ? LINE1 : LINE2;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ADDR: begin
        if (wr_done_s) begin
          state_nx_s = DATA;
          idx_nx_s   = 5'd1;
          wr_start_s = 1'b1;
          wr_rs_s    = 1'b1;
          wr_byte_s  = line_char(line_r, 4'd0);
        end else begin
          state_nx_s = ADDR;
        end
      end
      DATA: begin
        if (wr_done_s) begin
          if (idx_r == LINE_LEN) begin
            state_nx_s = ACK;
          end else begin
            wr_start_s = 1'b1;
            wr_rs_s    = 1'b1;
            wr_byte_s  = line_char(line_r, idx_r[3:0]);
            idx_nx_s   = idx_r + 5'd1;
          end
        end else begin
          state_nx_s = DATA;
        end
      end
      ACK: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = PWRUP;
        cnt_nx_s   = 32'd0;
      end
    endcase
  end

  // Sequencing state and registered status outputs.
  always_ff @(posedge ckht or posedge rst) begin
    if (rst) begin
      state_r      <= PWRUP;
      cnt_r        <= 32'd0;
      idx_r        <= 5'd0;
      line_r       <= 128'd0;
      last_grant_r <= LAP;
      init_done_r  <= 1'b0;
      busy_r       <= 1'b1;
      ack_live_r   <= 1'b0;
      ack_lap_r    <= 1'b0;
      lcd_p_r      <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      cnt_r        <= cnt_nx_s;
      idx_r        <= idx_nx_s;
      line_r       <= line_nx_s;
      last_grant_r <= last_nx_s;
      init_done_r  <= init_done_nx_s;
      busy_r       <= (state_nx_s != IDLE);
      ack_live_r   <= (state_nx_s == ACK) && (last_nx_s == LIVE);
      ack_lap_r    <= (state_nx_s == ACK) && (last_nx_s == LAP);
      lcd_p_r      <= 1'b1;
    end
  end

  lcd_byte_writer #(
    .E_HIGH_CYC   (E_HIGH_CYC),
    .CMD_WAIT_CYC (CMD_WAIT_CYC),
    .CLR_WAIT_CYC (CLR_WAIT_CYC)
  ) u_writer (
    .ckht     (ckht),
    .rst      (rst),
    .start    (wr_start_s),
    .wr_byte  (wr_byte_s),
    .rs_in    (wr_rs_s),
    .is_clear (wr_clr_s),
    .done     (wr_done_s),
    .lcd_db   (lcd_db),
    .lcd_rs   (lcd_rs),
    .lcd_e    (lcd_e)
  );

  assign ack_live  = ack_live_r;
  assign ack_lap   = ack_lap_r;
  assign busy      = busy_r;
  assign init_done = init_done_r;
  assign lcd_p     = lcd_p_r;

endmodule

// File: tb/tb_lcd_line_arbiter.sv
// Scoreboard bench for lcd_line_arbiter: stimulus pushes the expected
// strobed bytes and acks; an independent monitor pops and compares them.
module tb_lcd_line_arbiter;

  localparam int PW  = 20;
  localparam int EH  = 2;
  localparam int CW  = 4;
  localparam int CLW = 10;
  localparam int WK  = 30;
  localparam int XFER_LAT = 153;   // 17 * (3 + 2 + 4)

`ifdef LCD_INIT_REPEAT_EN
  localparam int N_INIT = 7;
  localparam int INIT_DONE_EDGES = 115; // 20 + 35 + 9 + 9 + 9 + 9 + 9 + 15
  logic [7:0] init_seq [7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h06, 8'h01};
`else
  localparam int N_INIT = 4;
  localparam int INIT_DONE_EDGES = 62;  // 20 + 9 + 9 + 9 + 15
  logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
`endif

  logic         ckht = 1'b0;
  logic         rst = 1'b1;
  logic         req_live = 1'b0;
  logic         req_lap = 1'b0;
  logic [127:0] data_live = 128'd0;
  logic [127:0] data_lap = 128'd0;
  logic         ack_live, ack_lap, busy, init_done;
  logic [7:0]   lcd_db;
  logic         lcd_rs, lcd_e, lcd_p;

  lcd_line_arbiter #(
    .CLK_HZ        (50_000_000),
    .PWRUP_CYC     (PW),
    .E_HIGH_CYC    (EH),
    .CMD_WAIT_CYC  (CW),
    .CLR_WAIT_CYC  (CLW),
    .WAKE_WAIT_CYC (WK)
  ) dut (
    .ckht      (ckht),
    .rst       (rst),
    .req_live  (req_live),
    .data_live (data_live),
    .req_lap   (req_lap),
    .data_lap  (data_lap),
    .ack_live  (ack_live),
    .ack_lap   (ack_lap),
    .busy      (busy),
    .init_done (init_done),
    .lcd_db    (lcd_db),
    .lcd_rs    (lcd_rs),
    .lcd_e     (lcd_e),
    .lcd_p     (lcd_p)
  );

  always #5 ckht = ~ckht;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_byte_q [$];   // {rs, db}
  logic       exp_ack_q [$];    // 0 = live, 1 = lap
  int cyc = 0;
  int grant_cyc = 0;

  localparam logic [127:0] LIVE1 = "00:01:23.45     ";
  localparam logic [127:0] LIVE2 = "00:02:00.00     ";
  localparam logic [127:0] LAP1  = "L1 00:00:59.99  ";
  localparam logic [127:0] LAP2  = "L2 00:01:59.50  ";
  localparam logic [127:0] JUNK  = "XXXXXXXXXXXXXXXX";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_init();
    for (int i = 0; i < N_INIT; i++) exp_byte_q.push_back({1'b0, init_seq[i]});
  endtask

  task automatic push_line(input logic [7:0] cmd, input logic [127:0] txt, input logic id);
    exp_byte_q.push_back({1'b0, cmd});
    for (int i = 0; i < 16; i++) exp_byte_q.push_back({1'b1, txt[127-8*i -: 8]});
    exp_ack_q.push_back(id);
  endtask

  // Counts edges from reset release until init_done, checking lcd_p after edge 1.
  task automatic wait_init(input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 3000) begin
      @(posedge ckht); #1;
      n++;
      if (n == 1) chk({name, "_lcd_p"}, 32'(lcd_p), 32'd1);
      if (init_done) seen = 1'b1;
    end
    chk({name, "_init_edges"}, 32'(n), 32'(INIT_DONE_EDGES));
  endtask

  // Waits for an ack and drops the matching request in the ack cycle.
  task automatic wait_ack(input logic lap, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge ckht); #1;
      if (lap ? ack_lap : ack_live) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
    if (lap) req_lap = 1'b0;
    else     req_live = 1'b0;
  endtask

  // Monitor: strobe bytes, E-high width, acks and grant-to-ack latency.
  initial begin
    logic e_prev = 1'b0;
    logic busy_prev = 1'b1;
    int e_w = 0;
    forever begin
      @(negedge ckht);
      cyc++;
      if (rst) begin
        e_prev = 1'b0;
        busy_prev = 1'b1;
        e_w = 0;
      end else begin
        if (lcd_e && !e_prev) begin
          e_w = 1;
          if (exp_byte_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL strobe_unexpected actual=%0h expected=none at t=%0t", {lcd_rs, lcd_db}, $time);
          end else begin
            chk("strobe_byte", 32'({lcd_rs, lcd_db}), 32'(exp_byte_q.pop_front()));
          end
        end else if (lcd_e) begin
          e_w++;
        end else if (e_prev) begin
          chk("e_high_width", 32'(e_w), 32'(EH));
        end
        if (ack_live || ack_lap) begin
          chk("ack_one_hot", 32'(ack_live & ack_lap), 32'd0);
          if (exp_ack_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL ack_unexpected actual=%0d%0d expected=none at t=%0t", ack_live, ack_lap, $time);
          end else begin
            chk("ack_order", 32'(ack_lap), 32'(exp_ack_q.pop_front()));
            chk("ack_latency", 32'(cyc - grant_cyc), 32'(XFER_LAT));
          end
        end
        if (busy && !busy_prev) grant_cyc = cyc;
        e_prev = lcd_e;
        busy_prev = busy;
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values.
    repeat (3) @(posedge ckht);
    #1;
    chk("rst_lcd_p", 32'(lcd_p), 32'd0);
    chk("rst_lcd_e", 32'(lcd_e), 32'd0);
    chk("rst_lcd_db", 32'(lcd_db), 32'd0);
    chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_acks", 32'({ack_live, ack_lap}), 32'd0);

    // Release; lap request raised during power-up waits for init.
    @(negedge ckht);
    push_init();
    push_line(8'hC0, LAP1, 1'b1);
    rst = 1'b0;
    #2;
    data_lap = LAP1;
    req_lap = 1'b1;
    wait_init("init1");
    wait_ack(1'b1, "ack_lap_after_init");

    // Simultaneous requests with last_grant = LAP: live first, then lap.
    repeat (3) @(posedge ckht);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    data_live = LIVE2;
    data_lap = LAP2;
    push_line(8'h80, LIVE2, 1'b0);
    push_line(8'hC0, LAP2, 1'b1);
    req_live = 1'b1;
    req_lap = 1'b1;
    wait_ack(1'b0, "ack_live_tie");
    wait_ack(1'b1, "ack_lap_tie");

    // Single live request; data changed after grant and a short lap pulse
    // dropped before any grant must both have no effect.
    repeat (4) @(posedge ckht);
    #1;
    data_live = LIVE1;
    push_line(8'h80, LIVE1, 1'b0);
    req_live = 1'b1;
    repeat (3) @(posedge ckht);
    #1;
    data_live = JUNK;
    req_lap = 1'b1;
    repeat (3) @(posedge ckht);
    #1;
    req_lap = 1'b0;
    wait_ack(1'b0, "ack_live_single");

    // Reset in the middle of the DATA phase, while lcd_e is high.
    repeat (3) @(posedge ckht);
    #1;
    data_lap = LAP2;
    push_line(8'hC0, LAP2, 1'b1);
    req_lap = 1'b1;
    begin
      bit hit = 1'b0;
      int k = 0;
      repeat (5) @(posedge ckht);
      while (!hit && k < 300) begin
        @(posedge ckht); #1;
        k++;
        if (lcd_e && lcd_rs) hit = 1'b1;
      end
      chk("reach_data_phase", 32'(hit), 32'd1);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_lcd_e", 32'(lcd_e), 32'd0);
    chk("midrst_lcd_p", 32'(lcd_p), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    exp_byte_q.delete();
    exp_ack_q.delete();
    req_lap = 1'b0;
    repeat (3) @(posedge ckht);
    @(negedge ckht);
    push_init();
    rst = 1'b0;
    wait_init("init2");

    // Quiet period: no ack for the aborted transfer, no stray strobes.
    repeat (200) @(posedge ckht);
    #1;
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_lcd_e", 32'(lcd_e), 32'd0);
    chk("end_byte_q_empty", 32'(exp_byte_q.size()), 32'd0);
    chk("end_ack_q_empty", 32'(exp_ack_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
